mem_stage: RTL

Memory stage of the five-stage pipeline CPU, directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM control and data outputs, performs the data-memory load/store and the branch/jump decision, and registers the results into the MEM/WB pipeline register that feeds write-back.

---
 rtl/mem_stage_pkg.sv | 17 +
 rtl/mem_stage_data_mem.sv | 26 ++
 rtl/mem_stage.sv | 100 ++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM stage.
// The MEM/WB register layout lives here so the stage and its users agree on it.
package mem_stage_pkg;

  localparam int WORD_W        = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int DEFAULT_DEPTH = 256;

  typedef struct packed {
    logic                  memtoreg;
    logic                  regwrite;
    logic                  rd_valid;
    logic [WORD_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] reg_dst;
  } memwb_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// data_mem: synchronous single-port RAM with a registered, read-before-write read port.
// The read register holds its value when re is low; the caller masks it.
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // NOTE: no reset on the array or rdata so the tools can map this onto block RAM;
  // NOTE: non-blocking assignments make a same-edge read return the old word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata     <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access, branch decision and the MEM/WB pipeline register.
// Optional build macro: MEM_ALIGN_CHECK_EN enables the sticky misalignment check.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  startin,
  input  logic                  jumpIn,
  input  logic                  branchIn,
  input  logic                  memreadIn,
  input  logic                  memwriteIn,
  input  logic                  memtoregIn,
  input  logic                  regwriteIn,
  input  logic                  zeroIn,
  input  logic [WORD_W-1:0]     aluResultIn,
  input  logic [WORD_W-1:0]     read2In,
  input  logic [REG_ADDR_W-1:0] regDstMuxIn,
  output logic                  pcSrc,
  output logic                  jump,
  output logic                  memtoreg,
  output logic                  regwrite,
  output logic [WORD_W-1:0]     readData,
  output logic [WORD_W-1:0]     aluResult,
  output logic [REG_ADDR_W-1:0] regDstMux,
  output logic                  alignErr
);

  logic [ADDR_W-1:0] index;
  logic              misalign;
  logic              we;
  logic              re;
  logic [WORD_W-1:0] mem_rdata;
  memwb_t            memwb_d;
  memwb_t            memwb_q;

  assign pcSrc = branchIn & zeroIn;
  assign jump  = jumpIn;

  // Upper address bits are dropped, so accesses wrap modulo DEPTH words.
  assign index = aluResultIn[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = (aluResultIn[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Stores are gated by startin because an asynchronous reset alone cannot block the RAM write.
  assign we = memwriteIn & startin & ~misalign;
  assign re = memreadIn & ~misalign;

  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (index),
    .wdata (read2In),
    .rdata (mem_rdata)
  );

  always_comb begin
    memwb_d.memtoreg   = memtoregIn;
    memwb_d.regwrite   = regwriteIn & ~(memreadIn & misalign);
    memwb_d.rd_valid   = re;
    memwb_d.alu_result = aluResultIn;
    memwb_d.reg_dst    = regDstMuxIn;
  end

  always_ff @(posedge clk or negedge startin) begin
    if (!startin) memwb_q <= '0;
    else          memwb_q <= memwb_d;
  end

  assign memtoreg  = memwb_q.memtoreg;
  assign regwrite  = memwb_q.regwrite;
  assign aluResult = memwb_q.alu_result;
  assign regDstMux = memwb_q.reg_dst;
  // rd_valid resets asynchronously, which is what forces readData to 0 during reset.
  assign readData  = memwb_q.rd_valid ? mem_rdata : '0;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;

  always_ff @(posedge clk or negedge startin) begin
    if (!startin)                                   align_err_q <= 1'b0;
    else if ((memreadIn | memwriteIn) & misalign)   align_err_q <= 1'b1;
  end

  assign alignErr = align_err_q;
`else
  assign alignErr = 1'b0;
`endif

endmodule
